// File: rtl/snow_vi_aes_round_sched.sv
// snow_vi_aes_round_sched
//   Time-shares one keyless combinational AES round among NUM_REQ requesters.
//   A round-robin arbiter grants one request at a time. The operand is
//   registered into in_reg, presented on round_block for one CALC cycle, and
//   the round output is captured into the response registers. The response is
//   held on a valid/ready channel until it is consumed.
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req_valid/ready   per-requester handshake (ready is one-hot or zero)
//   req_block         requester i operand at [i*128 +: 128]
//   round_block       registered operand to the shared AES round
//   round_result      combinational AES round output
//   resp_valid/ready  response handshake; resp_id names the owning requester
//   resp_block        captured AES round result
//   busy              high whenever the FSM is not IDLE
//   op_count          completed response handshakes, wraps at 2**32
module snow_vi_aes_round_sched #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_block,
  output logic [127:0]           round_block,
  input  logic [127:0]           round_result,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [127:0]           resp_block,
  output logic                   busy,
  output logic [31:0]            op_count
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] id_reg;
  logic [127:0]    in_reg;
  logic [ID_W-1:0] gnt;
  logic            gnt_vld;
  logic [ID_W-1:0] rr_nxt;
  logic            accept;

  // Rotating priority search: first valid requester at or above rr_ptr.
  // rr_ptr is always below NUM_REQ, so a single subtraction wraps the index.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_vld && req_valid[idx]) begin
        gnt     = ID_W'(idx);
        gnt_vld = 1'b1;
      end
    end
  end

  assign req_ready   = (state == IDLE && gnt_vld) ? (NUM_REQ'(1) << gnt) : '0;
  assign accept      = |(req_valid & req_ready);
  assign rr_nxt      = (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;
  // Operand always comes from a register so the round path starts at a flop.
  assign round_block = in_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      id_reg     <= '0;
      in_reg     <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_block <= '0;
      busy       <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_reg <= req_block[int'(gnt)*128 +: 128];
            id_reg <= gnt;
            rr_ptr <= rr_nxt;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          resp_block <= round_result;
          resp_id    <= id_reg;
          resp_valid <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          // No grant in the handshake cycle: IDLE is entered first.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            op_count   <= op_count + 32'd1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snow_vi_aes_round_sched.sv
module tb_snow_vi_aes_round_sched;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*128-1:0] req_block;
  logic [127:0]           round_block;
  logic [127:0]           round_result;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [ID_W-1:0]        resp_id;
  logic [127:0]           resp_block;
  logic                   busy;
  logic [31:0]            op_count;

  snow_vi_aes_round_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_block(req_block), .round_block(round_block), .round_result(round_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_block(resp_block), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // ---------------- keyless AES round model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r ^ rl(r, 1) ^ rl(r, 2) ^ rl(r, 3) ^ rl(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] blk);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(blk[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
      o[127-32*c -: 8]    = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
      o[127-32*c-8 -: 8]  = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
      o[127-32*c-16 -: 8] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
      o[127-32*c-24 -: 8] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
    end
    return o;
  endfunction

  always_comb round_result = aes_round(round_block);

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  typedef struct {
    int           id;
    logic [127:0] blk;
    int           t;
  } exp_t;

  exp_t        sb[$];
  int          gnt_log[$];
  int          cyc = 0;
  logic [31:0] exp_ops = '0;
  logic        prev_rv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard push on accept, pop on response handshake.
  always @(negedge clk) begin
    chk("op_count", {96'h0, op_count}, {96'h0, exp_ops});
    if (reset) begin
      sb.delete();
      exp_ops = '0;
      prev_rv = 1'b0;
    end else begin
      if (|(req_valid & req_ready)) begin
        exp_t e;
        int g;
        g = 0;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) g = i;
        e.id  = g;
        e.blk = aes_round(req_block[g*128 +: 128]);
        e.t   = cyc;
        sb.push_back(e);
        gnt_log.push_back(g);
      end
      if (resp_valid && !prev_rv) begin
        if (sb.size() == 0) chk("stale_resp", 128'(sb.size()), 128'd1);
        else chk("latency", 128'(cyc - sb[0].t), 128'd2);
      end
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) chk("resp_no_exp", 128'(sb.size()), 128'd1);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_id", 128'(resp_id), 128'(e.id));
          chk("resp_block", resp_block, e.blk);
          exp_ops = exp_ops + 32'd1;
        end
      end
      prev_rv = resp_valid;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_req(input int i, input logic [127:0] blk);
    req_block[i*128 +: 128] = blk;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_acc(input int i);
    logic got;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (req_valid[i] && req_ready[i]) got = 1'b1;
    end
    chk($sformatf("accept_r%0d", i), 128'(got), 128'd1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic req_one(input int i, input logic [127:0] blk);
    start_req(i, blk);
    wait_acc(i);
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !resp_valid && !busy) done = 1'b1;
    end
    chk("drain", 128'(done), 128'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] bx, blk;
    int base;
    logic got;
    reset = 1'b1; req_valid = '0; req_block = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", 128'(resp_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_req_ready", 128'(req_ready), 128'd0);
    chk("rst_resp_id", 128'(resp_id), 128'd0);
    chk("rst_resp_block", resp_block, 128'd0);
    chk("rst_round_block", round_block, 128'd0);
    @(posedge clk); #1 reset = 1'b0;

    // 1: requester 0, zero block
    req_one(0, 128'd0);
    drain();
    chk("t1_block", resp_block, {16{8'h63}});
    chk("t1_op_count", 128'(op_count), 128'd1);

    // 2: requester 1, all-0x63 block
    req_one(1, {16{8'h63}});
    drain();
    chk("t2_block", resp_block, {16{8'hfb}});
    chk("t2_id", 128'(resp_id), 128'd1);

    // a few random blocks through alternating requesters
    for (int k = 0; k < 4; k++) begin
      req_one(k % NUM_REQ, {$urandom, $urandom, $urandom, $urandom});
      drain();
    end

    // 4: consumer stalls in DONE for 10 cycles
    resp_ready = 1'b0;
    bx = {$urandom, $urandom, $urandom, $urandom};
    req_one(0, bx);
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (resp_valid) got = 1'b1;
    end
    chk("t4_resp_seen", 128'(got), 128'd1);
    @(posedge clk); #1;
    start_req(1, 128'h0123456789abcdef_fedcba9876543210);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("t4_hold_valid", 128'(resp_valid), 128'd1);
      chk("t4_hold_id", 128'(resp_id), 128'd0);
      chk("t4_hold_block", resp_block, aes_round(bx));
      chk("t4_req_ready", 128'(req_ready), 128'd0);
      chk("t4_busy", 128'(busy), 128'd1);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    wait_acc(1);
    drain();

    // 3: both requesters valid continuously from reset
    reset = 1'b1;
    start_req(0, 128'h11111111_22222222_33333333_44444444);
    start_req(1, 128'h55555555_66666666_77777777_88888888);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    base = gnt_log.size();
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (gnt_log.size() >= base + 4) got = 1'b1;
    end
    chk("t3_four_grants", 128'(got), 128'd1);
    @(posedge clk); #1 req_valid = '0;
    drain();
    for (int k = 0; k < 4; k++)
      chk($sformatf("t3_order%0d", k), 128'(gnt_log[base+k]), 128'(k % 2));
    chk("t3_op_count", 128'(op_count), 128'd4);

    // 5: reset while CALC is in flight (rr_ptr is 1 after this grant)
    req_one(0, 128'hdeadbeef_00000000_cafef00d_12345678);
    reset = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t5_resp_valid", 128'(resp_valid), 128'd0);
    chk("t5_busy", 128'(busy), 128'd0);
    chk("t5_op_count", 128'(op_count), 128'd0);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("t5_no_stale", 128'(resp_valid), 128'd0);
    end
    @(posedge clk); #1;
    base = gnt_log.size();
    start_req(0, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0);
    start_req(1, 128'h00000001_00000002_00000003_00000004);
    wait_acc(0);
    wait_acc(1);
    drain();
    chk("t5_rr_reset", 128'(gnt_log[base]), 128'd0);

    // 6: op_count wrap
    force dut.op_count = 32'hffffffff;
    exp_ops = 32'hffffffff;
    @(posedge clk); #1;
    release dut.op_count;
    blk = {$urandom, $urandom, $urandom, $urandom};
    req_one(1, blk);
    drain();
    chk("t6_wrap", 128'(op_count), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
